// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with MEM/WB register and req/gnt/rvalid data-memory port
// Optional misaligned word-access trap: define MEM_ALIGN_CHECK_EN.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   MEM_alu_out,
    input  logic [XLEN-1:0]   MEM_b2,
    input  logic [4:0]        MEM_rd,
    input  logic              MEM_we,
    input  logic              MEM_ld,
    input  logic              MEM_str,
    input  logic              MEM_byt,
    output logic              MEM_stall,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [XLEN-1:0]   WB_data,
    output logic [4:0]        WB_rd,
    output logic              WB_we,
    output logic              MEM_fault
);
    localparam int NB = XLEN / 8;

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;

    logic            mem_op;
    logic            is_store;
    logic            misaligned;
    logic            issue;
    logic [1:0]      lane;
    logic [7:0]      rd_byte;
    logic [XLEN-1:0] load_val;
    logic [NB-1:0]   strb_one;
    logic            wb_en;
    logic            wb_we_nxt;
    logic [XLEN-1:0] wb_data_nxt;
    logic            fault_nxt;

    assign mem_op   = MEM_ld | MEM_str;
    assign is_store = MEM_str & ~MEM_ld;
    assign lane     = MEM_alu_out[1:0];
    assign strb_one = {{(NB-1){1'b0}}, 1'b1};

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & ~MEM_byt & (lane != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign issue = mem_op & ~misaligned;

    assign dmem_wr    = is_store;
    assign dmem_addr  = {MEM_alu_out[XLEN-1:2], 2'b00};
    assign dmem_wdata = MEM_byt ? {NB{MEM_b2[7:0]}} : MEM_b2;
    assign dmem_wstrb = !is_store ? '0 : (MEM_byt ? (strb_one << lane) : '1);

    // Upstream is held during the transaction, so the lane is still valid at rvalid.
    assign rd_byte  = dmem_rdata[{lane, 3'b000} +: 8];
    assign load_val = MEM_byt ? {{(XLEN-8){1'b0}}, rd_byte} : dmem_rdata;

    always_comb begin
        state_nxt   = state;
        dmem_req    = 1'b0;
        MEM_stall   = 1'b0;
        wb_en       = 1'b0;
        wb_we_nxt   = 1'b0;
        wb_data_nxt = MEM_alu_out;
        fault_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    dmem_req  = 1'b1;
                    MEM_stall = 1'b1;
                    if (dmem_gnt) state_nxt = WAIT;
                end else begin
                    wb_en     = 1'b1;
                    wb_we_nxt = MEM_we & ~misaligned;
                    fault_nxt = misaligned;
                end
            end
            WAIT: begin
                MEM_stall = ~dmem_rvalid;
                if (dmem_rvalid) begin
                    wb_en       = 1'b1;
                    wb_we_nxt   = MEM_we;
                    wb_data_nxt = MEM_ld ? load_val : MEM_alu_out;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stalled cycles leave data/rd alone but always clear WB_we (bubble).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            WB_data   <= '0;
            WB_rd     <= '0;
            WB_we     <= 1'b0;
            MEM_fault <= 1'b0;
        end else begin
            state     <= state_nxt;
            WB_we     <= wb_we_nxt;
            MEM_fault <= fault_nxt;
            if (wb_en) begin
                WB_data <= wb_data_nxt;
                WB_rd   <= MEM_rd;
            end
        end
    end
endmodule
